// File: rtl/kamacore_stage_mem_if.sv
// Bus bundle between the MEM pipeline stage and its neighbours: the EX->MEM
// entry handshake, the data-memory request/response port and the MEM->WB
// result. The stage itself connects through the master modport; the
// surrounding pipeline/memory model connects through the slave modport.
interface kamacore_stage_mem_if #(
    parameter int CPU_WIDTH = 32
);
    // EX -> MEM entry
    logic                 ex_valid;
    logic                 ex_ready;
    logic [CPU_WIDTH-1:0] ex_instruction;
    logic [CPU_WIDTH-1:0] ex_alu_result;
    logic [CPU_WIDTH-1:0] ex_rs2_data;

    // data memory port
    logic                 dmem_req;
    logic                 dmem_we;
    logic [CPU_WIDTH-1:0] dmem_addr;
    logic [3:0]           dmem_be;
    logic [CPU_WIDTH-1:0] dmem_wdata;
    logic                 dmem_gnt;
    logic                 dmem_rvalid;
    logic [CPU_WIDTH-1:0] dmem_rdata;

    // MEM -> WB result
    logic                 wb_valid;
    logic [CPU_WIDTH-1:0] wb_instruction;
    logic [CPU_WIDTH-1:0] wb_result;
    logic                 mem_misaligned;

    modport master (
        input  ex_valid, ex_instruction, ex_alu_result, ex_rs2_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output ex_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output wb_valid, wb_instruction, wb_result, mem_misaligned
    );

    modport slave (
        output ex_valid, ex_instruction, ex_alu_result, ex_rs2_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  wb_valid, wb_instruction, wb_result, mem_misaligned
    );
endinterface

// File: rtl/kamacore_stage_mem.sv
// MEM pipeline stage: passes non-memory instructions straight to writeback,
// issues loads/stores on the data-memory port (req/gnt, then rvalid for
// loads), lane-aligns store data and extracts/extends load data.
// Optional feature: define KAMACORE_MISALIGN_TRAP_EN to flag misaligned
// halfword/word accesses instead of issuing them; without it the offending
// low address bits are forced to zero and the access proceeds.
module kamacore_stage_mem #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    kamacore_stage_mem_if.master   bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t               state_reg;
    logic [CPU_WIDTH-1:0] instr_reg;
    logic [CPU_WIDTH-1:0] addr_reg;
    logic [CPU_WIDTH-1:0] wdata_reg;
    logic [3:0]           be_reg;
    logic                 we_reg;
    logic [2:0]           funct3_reg;
    logic                 req_reg;
    logic                 wb_valid_reg;
    logic [CPU_WIDTH-1:0] wb_instr_reg;
    logic [CPU_WIDTH-1:0] wb_result_reg;
    logic                 misaligned_reg;

    // decode of the entry currently offered by EX
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 is_load;
    logic                 is_store;
    logic                 is_mem;
    logic                 size_half;
    logic                 size_word;
    logic [CPU_WIDTH-1:0] eff_addr;
    logic [3:0]           lane_be;
    logic [CPU_WIDTH-1:0] lane_wdata;
    logic                 trap;
    logic [CPU_WIDTH-1:0] ld_lane;
    logic [CPU_WIDTH-1:0] ld_data;

    // classify the EX entry; unknown funct3 falls back to pass-through
    always_comb begin
        opcode    = bus.ex_instruction[6:0];
        funct3    = bus.ex_instruction[14:12];
        is_load   = (opcode == OP_LOAD)  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store  = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});
        is_mem    = is_load || is_store;
        size_half = (funct3[1:0] == 2'b01);
        size_word = (funct3[1:0] == 2'b10);
        eff_addr  = bus.ex_alu_result;
        if (size_half) eff_addr[0]   = 1'b0;
        if (size_word) eff_addr[1:0] = 2'b00;
    end

`ifdef KAMACORE_MISALIGN_TRAP_EN
    assign trap = (size_half && bus.ex_alu_result[0]) ||
                  (size_word && (bus.ex_alu_result[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // per byte lane: enable and replicated store data
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_be[gi] = size_word ? 1'b1 :
                                 size_half ? (eff_addr[1] == LANE[1]) :
                                             (eff_addr[1:0] == LANE);
            assign lane_wdata[8*gi +: 8] = size_word ? bus.ex_rs2_data[8*gi +: 8] :
                                           size_half ? bus.ex_rs2_data[8*(gi%2) +: 8] :
                                                       bus.ex_rs2_data[7:0];
        end
    endgenerate

    // shift the addressed lane down and extend according to the load type
    always_comb begin
        ld_lane = bus.dmem_rdata >> {addr_reg[1:0], 3'b000};
        case (funct3_reg)
            3'b000:  ld_data = {{(CPU_WIDTH-8){ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_data = {{(CPU_WIDTH-16){ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_data = {{(CPU_WIDTH-8){1'b0}}, ld_lane[7:0]};
            3'b101:  ld_data = {{(CPU_WIDTH-16){1'b0}}, ld_lane[15:0]};
            default: ld_data = ld_lane;
        endcase
    end

    // stage FSM with all bus outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            instr_reg      <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            we_reg         <= 1'b0;
            funct3_reg     <= '0;
            req_reg        <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_instr_reg   <= '0;
            wb_result_reg  <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            wb_valid_reg   <= 1'b0;
            misaligned_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        if (!is_mem) begin
                            wb_valid_reg  <= 1'b1;
                            wb_instr_reg  <= bus.ex_instruction;
                            wb_result_reg <= bus.ex_alu_result;
                        end else if (trap) begin
                            wb_valid_reg   <= 1'b1;
                            wb_instr_reg   <= bus.ex_instruction;
                            wb_result_reg  <= bus.ex_alu_result;
                            misaligned_reg <= 1'b1;
                        end else begin
                            instr_reg  <= bus.ex_instruction;
                            addr_reg   <= eff_addr;
                            wdata_reg  <= is_store ? lane_wdata : '0;
                            be_reg     <= lane_be;
                            we_reg     <= is_store;
                            funct3_reg <= funct3;
                            req_reg    <= 1'b1;
                            state_reg  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.dmem_gnt) begin
                        req_reg <= 1'b0;
                        if (we_reg) begin
                            wb_valid_reg  <= 1'b1;
                            wb_instr_reg  <= instr_reg;
                            wb_result_reg <= '0;
                            state_reg     <= ST_IDLE;
                        end else if (bus.dmem_rvalid) begin
                            wb_valid_reg  <= 1'b1;
                            wb_instr_reg  <= instr_reg;
                            wb_result_reg <= ld_data;
                            state_reg     <= ST_IDLE;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        wb_valid_reg  <= 1'b1;
                        wb_instr_reg  <= instr_reg;
                        wb_result_reg <= ld_data;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ex_ready       = (state_reg == ST_IDLE);
    assign bus.dmem_req       = req_reg;
    assign bus.dmem_we        = we_reg;
    assign bus.dmem_addr      = {addr_reg[CPU_WIDTH-1:2], 2'b00};
    assign bus.dmem_be        = be_reg;
    assign bus.dmem_wdata     = wdata_reg;
    assign bus.wb_valid       = wb_valid_reg;
    assign bus.wb_instruction = wb_instr_reg;
    assign bus.wb_result      = wb_result_reg;
    assign bus.mem_misaligned = misaligned_reg;
endmodule

// File: tb/tb_kamacore_stage_mem.sv
// Directed bench for kamacore_stage_mem: pass-through, stores, loads,
// misaligned handling (both builds of KAMACORE_MISALIGN_TRAP_EN) and reset.
module tb_kamacore_stage_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    kamacore_stage_mem_if #(.CPU_WIDTH(32)) bus ();

    kamacore_stage_mem #(.CPU_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd1, op};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] rs2);
        bus.ex_valid       = 1'b1;
        bus.ex_instruction = instr;
        bus.ex_alu_result  = addr;
        bus.ex_rs2_data    = rs2;
        tick();
        bus.ex_valid       = 1'b0;
    endtask

    // one memory transaction: gnt after gnt_wait extra REQ cycles,
    // rvalid rv_wait cycles after gnt (0 = same cycle as gnt)
    task automatic mem_op(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                          input logic [31:0] rs2, input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdata, input logic is_store,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_result);
        offer(instr, addr, rs2);
        for (int i = 0; i <= gnt_wait; i++) begin
            check({tag, "_req"},   32'(bus.dmem_req), 32'd1);
            check({tag, "_ready"}, 32'(bus.ex_ready), 32'd0);
            check({tag, "_addr"},  bus.dmem_addr, exp_addr);
            check({tag, "_be"},    32'(bus.dmem_be), 32'(exp_be));
            check({tag, "_we"},    32'(bus.dmem_we), 32'(is_store));
            if (is_store) check({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
            if (i == gnt_wait) begin
                bus.dmem_gnt = 1'b1;
                if (!is_store && rv_wait == 0) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata  = rdata;
                end
            end
            tick();
        end
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        if (!is_store && rv_wait > 0) begin
            for (int i = 1; i <= rv_wait; i++) begin
                check({tag, "_wait_req"}, 32'(bus.dmem_req), 32'd0);
                check({tag, "_wait_wbv"}, 32'(bus.wb_valid), 32'd0);
                if (i == rv_wait) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata  = rdata;
                end
                tick();
            end
            bus.dmem_rvalid = 1'b0;
        end
        check({tag, "_wbv"},    32'(bus.wb_valid), 32'd1);
        check({tag, "_result"}, bus.wb_result, exp_result);
        check({tag, "_winstr"}, bus.wb_instruction, instr);
        check({tag, "_idle"},   32'(bus.ex_ready), 32'd1);
        tick();
        check({tag, "_wbv_off"}, 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        bus.ex_valid       = 1'b0;
        bus.ex_instruction = '0;
        bus.ex_alu_result  = '0;
        bus.ex_rs2_data    = '0;
        bus.dmem_gnt       = 1'b0;
        bus.dmem_rvalid    = 1'b0;
        bus.dmem_rdata     = '0;

        // reset state
        tick(); tick();
        check("rst_ready", 32'(bus.ex_ready), 32'd1);
        check("rst_req",   32'(bus.dmem_req), 32'd0);
        check("rst_wbv",   32'(bus.wb_valid), 32'd0);
        check("rst_res",   bus.wb_result, 32'd0);
        check("rst_mis",   32'(bus.mem_misaligned), 32'd0);
        rst = 1'b0;
        tick();
        $display("step: reset done");

        // three back-to-back ADDI
        bus.ex_valid = 1'b1;
        bus.ex_instruction = enc(7'b0010011, 3'b000);
        bus.ex_alu_result  = 32'd1;
        tick();
        check("addi1_wbv", 32'(bus.wb_valid), 32'd1);
        check("addi1_res", bus.wb_result, 32'd1);
        bus.ex_alu_result = 32'd2;
        tick();
        check("addi2_wbv", 32'(bus.wb_valid), 32'd1);
        check("addi2_res", bus.wb_result, 32'd2);
        bus.ex_alu_result = 32'd3;
        tick();
        check("addi3_wbv", 32'(bus.wb_valid), 32'd1);
        check("addi3_res", bus.wb_result, 32'd3);
        bus.ex_valid = 1'b0;
        tick();
        check("addi_wbv_off", 32'(bus.wb_valid), 32'd0);
        check("addi_hold",    bus.wb_result, 32'd3);
        $display("step: back-to-back ADDI done");

        // stray rvalid in IDLE is ignored
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEADBEEF;
        tick();
        bus.dmem_rvalid = 1'b0;
        check("idle_rv_wbv", 32'(bus.wb_valid), 32'd0);
        check("idle_rv_req", 32'(bus.dmem_req), 32'd0);
        $display("step: idle rvalid ignored");

        // stores
        mem_op("sb", enc(7'b0100011, 3'b000), 32'h0000_1003, 32'h0000_00AB, 2, 0, 32'h0, 1'b1,
               32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
        $display("step: SB 0x1003 done");
        mem_op("sh", enc(7'b0100011, 3'b001), 32'h0000_1002, 32'h0000_1234, 0, 0, 32'h0, 1'b1,
               32'h0000_1000, 4'b1100, 32'h1234_1234, 32'h0);
        $display("step: SH 0x1002 done");
        mem_op("sw", enc(7'b0100011, 3'b010), 32'h0000_1004, 32'hCAFE_F00D, 1, 0, 32'h0, 1'b1,
               32'h0000_1004, 4'b1111, 32'hCAFE_F00D, 32'h0);
        $display("step: SW 0x1004 done");

        // loads
        mem_op("lb", enc(7'b0000011, 3'b000), 32'h0000_2001, 32'h0, 0, 3, 32'h0000_F000, 1'b0,
               32'h0000_2000, 4'b0010, 32'h0, 32'hFFFF_FFF0);
        $display("step: LB 0x2001 done");
        mem_op("lbu", enc(7'b0000011, 3'b100), 32'h0000_2001, 32'h0, 0, 3, 32'h0000_F000, 1'b0,
               32'h0000_2000, 4'b0010, 32'h0, 32'h0000_00F0);
        $display("step: LBU 0x2001 done");
        mem_op("lh", enc(7'b0000011, 3'b001), 32'h0000_2002, 32'h0, 1, 1, 32'h8001_0000, 1'b0,
               32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
        $display("step: LH 0x2002 done");
        mem_op("lhu", enc(7'b0000011, 3'b101), 32'h0000_2002, 32'h0, 0, 2, 32'h8001_0000, 1'b0,
               32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
        $display("step: LHU 0x2002 done");
        mem_op("lw_fast", enc(7'b0000011, 3'b010), 32'h0000_2008, 32'h0, 0, 0, 32'h1234_5678, 1'b0,
               32'h0000_2008, 4'b1111, 32'h0, 32'h1234_5678);
        $display("step: LW gnt+rvalid same cycle done");

        // undefined funct3 on a store opcode behaves as pass-through
        offer(enc(7'b0100011, 3'b011), 32'h0000_5555, 32'h0);
        check("undef_wbv", 32'(bus.wb_valid), 32'd1);
        check("undef_res", bus.wb_result, 32'h0000_5555);
        check("undef_req", 32'(bus.dmem_req), 32'd0);
        $display("step: undefined funct3 pass-through done");

        // misaligned LW 0x3002
`ifdef KAMACORE_MISALIGN_TRAP_EN
        offer(enc(7'b0000011, 3'b010), 32'h0000_3002, 32'h0);
        check("mis_req", 32'(bus.dmem_req), 32'd0);
        check("mis_wbv", 32'(bus.wb_valid), 32'd1);
        check("mis_flag", 32'(bus.mem_misaligned), 32'd1);
        check("mis_res", bus.wb_result, 32'h0000_3002);
        tick();
        check("mis_flag_off", 32'(bus.mem_misaligned), 32'd0);
        check("mis_wbv_off",  32'(bus.wb_valid), 32'd0);
        $display("step: misaligned LW trapped");
`else
        mem_op("lw_mis", enc(7'b0000011, 3'b010), 32'h0000_3002, 32'h0, 0, 1, 32'h1122_3344, 1'b0,
               32'h0000_3000, 4'b1111, 32'h0, 32'h1122_3344);
        check("mis_flag", 32'(bus.mem_misaligned), 32'd0);
        $display("step: misaligned LW issued aligned");
`endif

        // reset in the middle of WAIT, then a late response
        offer(enc(7'b0000011, 3'b010), 32'h0000_4000, 32'h0);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        check("mrst_in_wait", 32'(bus.ex_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mrst_ready",  32'(bus.ex_ready), 32'd1);
        check("mrst_req",    32'(bus.dmem_req), 32'd0);
        check("mrst_res",    bus.wb_result, 32'd0);
        check("mrst_winstr", bus.wb_instruction, 32'd0);
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h9999_9999;
        tick();
        bus.dmem_rvalid = 1'b0;
        check("mrst_late_wbv",   32'(bus.wb_valid), 32'd0);
        check("mrst_late_ready", 32'(bus.ex_ready), 32'd1);
        check("mrst_late_res",   bus.wb_result, 32'd0);
        $display("step: reset mid-WAIT done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kamacore_stage_mem.md
KAMACORE_STAGE_MEM -- requirements
Module: kamacore_stage_mem

Interface
REQ-001 Parameter CPU_WIDTH, default 32: datapath width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  EX→MEM entry valid.
REQ-005 ex_ready  output  1  MEM accepts entry this cycle.
REQ-006 ex_instruction  input  32  instruction from EX.
REQ-007 ex_alu_result  input  32  ALU result; effective address for loads/stores.
REQ-008 ex_rs2_data  input  32  store data.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 dmem_we  output  1  1 = store, 0 = load.
REQ-011 dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_wdata  output  32  lane-aligned store data.
REQ-014 dmem_gnt  input  1  request accepted.
REQ-015 dmem_rvalid / dmem_rdata  input  1 / 32  load response valid / data.
REQ-016 wb_valid  output  1  MEM→WB entry valid, single-cycle pulse per instruction.
REQ-017 wb_instruction / wb_result  output  32 / 32  instruction and result to writeback.
REQ-018 mem_misaligned  output  1  misaligned-access flag (see Configuration).

Function
REQ-019 Decode: opcode 0000011 = load, 0100011 = store, all others = pass-through.
REQ-020 FSM states IDLE, REQ, WAIT; ex_ready SHALL equal (state == IDLE).
REQ-021 IDLE, ex_valid, pass-through: next cycle wb_valid=1, wb_instruction=ex_instruction, wb_result=ex_alu_result; state stays IDLE (1-cycle latency, back-to-back).
REQ-022 IDLE, ex_valid, load/store: latch instruction, address, store data; go to REQ.
REQ-023 REQ: dmem_req=1 with dmem_we/addr/be/wdata stable from latched values until dmem_gnt sampled high.
REQ-024 REQ, gnt, store: next cycle wb_valid=1, wb_result=0, state IDLE.
REQ-025 REQ, gnt, load: go to WAIT; dmem_req=0.
REQ-026 WAIT: on dmem_rvalid, next cycle wb_valid=1 with extracted load data, state IDLE; rvalid in REQ or IDLE SHALL be ignored.
REQ-027 Store enables: SB be=0001<<addr[1:0], wdata=byte replicated ×4; SH be=0011<<addr[1:0], wdata=half replicated ×2; SW be=1111, wdata=rs2.
REQ-028 Load extract: byte lane = rdata>>(8·addr[1:0]); LB sign-extend 8, LBU zero-extend 8, LH sign-extend 16, LHU zero-extend 16, LW unchanged.
REQ-029 Undefined funct3 on load/store SHALL be treated as pass-through.
REQ-030 wb_valid SHALL be 0 in every cycle not listed above; wb_instruction/wb_result hold last values.
REQ-031 dmem_gnt and dmem_rvalid in the same cycle while in REQ SHALL complete the load directly (no WAIT).

Reset
REQ-032 Asserting rst in any state, including mid-transaction, SHALL immediately force state=IDLE, dmem_req=0, wb_valid=0, wb_instruction=0, wb_result=0, mem_misaligned=0, all latches 0.
REQ-033 A response arriving after reset deassertion for an aborted transaction SHALL be ignored (REQ-026).

Configuration
REQ-034 Macro KAMACORE_MISALIGN_TRAP_EN defined: halfword access with addr[0]=1 or word access with addr[1:0]≠0 SHALL NOT issue dmem_req; next cycle wb_valid=1, wb_result=address, mem_misaligned=1 for that cycle only.
REQ-035 Macro undefined: mem_misaligned tied 0; misaligned accesses SHALL proceed with the offending low address bits forced to 0 for halfword/word.

Verification
REQ-036 Reset mid-WAIT, then rvalid=1 → no wb_valid, state IDLE, ex_ready=1.
REQ-037 Three back-to-back ADDI, alu_result 1,2,3 → wb_valid three consecutive cycles, wb_result 1,2,3.
REQ-038 SB addr 0x1003, rs2=0x000000AB, gnt after 2 cycles → dmem_be=1000, wdata=0xABABABAB held 3 cycles, wb_valid 1 cycle later.
REQ-039 LB addr 0x2001, rdata=0x0000F000 after gnt+3 cycles → wb_result=0xFFFFFFF0; LBU same → 0x000000F0.
REQ-040 LW with gnt and rvalid same cycle, rdata=0x12345678 → wb_result=0x12345678 next cycle, WAIT skipped.
REQ-041 LW addr 0x3002: with KAMACORE_MISALIGN_TRAP_EN → no dmem_req, mem_misaligned=1, wb_result=0x3002; without → dmem_addr=0x3000.
